// File: rtl/gat_feat_rd_pkg.sv
// Shared definitions for the GAT new-feature BRAM reader: geometry of the
// feature BRAM, byte/word address relation and the reader FSM encoding.
package gat_feat_rd_pkg;

  localparam int NUM_SUBGRAPHS      = 2708;
  localparam int NUM_FEATURE_OUT    = 16;
  localparam int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT;
  localparam int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH);

  // The BRAM port is byte addressed; one word is four bytes.
  localparam int BYTE_ADDR_SHIFT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } rd_state_t;

endpackage

// File: rtl/gat_feat_rd_fifo.sv
// Small first-word-fall-through FIFO carrying a data word plus a last flag.
// The head is forced to zero while empty so the stream outputs idle at 0.
// Callers guarantee no push into a full FIFO unless a pop happens the same
// cycle; a pop while empty is ignored.
module gat_feat_rd_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          push_last,
  input  logic          pop,
  output logic [W-1:0]  head_data,
  output logic          head_last,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty     = (count == '0);
  assign do_pop    = pop && !empty;
  assign head_data = empty ? '0 : mem[rd_ptr][W-1:0];
  assign head_last = empty ? 1'b0 : mem[rd_ptr][W];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array, written on push; contents need no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {push_last, push_data};
  end

endmodule

// File: rtl/gat_feat_bram_reader.sv
// Host-side reader for the GAT new-feature BRAM read port. A start command
// (honoured only while gat_ready is high) drains a contiguous word range,
// absorbs the fixed BRAM read latency with a tag pipeline, and streams the
// words out on valid/ready with TLAST. Reads are only issued when the
// prefetch FIFO is guaranteed room, so backpressure never drops data.
//
// Stream handshake: a beat transfers on a rising clk edge where m_tvalid and
// m_tready are both high; once m_tvalid is high, m_tdata/m_tlast stay stable
// until that transfer.
//
// Optional build macro FEAT_RD_CHECKSUM_EN adds a 32-bit wrap-around sum of
// the transferred words of the current command on port checksum.
module gat_feat_bram_reader
  import gat_feat_rd_pkg::*;
#(
  parameter int NEW_FEATURE_WIDTH = 32,
  parameter int RD_LATENCY        = 2,
  parameter int FIFO_DEPTH        = RD_LATENCY + 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          gat_ready,
  input  logic                          start,
  input  logic [NEW_FEATURE_ADDR_W-1:0] base_word,
  input  logic [NEW_FEATURE_ADDR_W:0]   num_words,
  output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
  output logic [NEW_FEATURE_WIDTH-1:0]  m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic                          busy,
  output logic                          done,
  output logic                          err_range
`ifdef FEAT_RD_CHECKSUM_EN
  ,
  output logic [31:0]                   checksum
`endif
);

  localparam int AW = NEW_FEATURE_ADDR_W;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  rd_state_t              state;
  rd_state_t              state_nxt;
  logic [AW-1:0]          word_idx;
  logic [AW:0]            remaining;
  logic [RD_LATENCY-1:0]  tag_v;
  logic [RD_LATENCY-1:0]  tag_l;
  logic [CW-1:0]          inflight;
  logic [CW-1:0]          fifo_count;
  logic                   fifo_empty;
  logic [AW+1:0]          end_word;
  logic [CW:0]            occupancy;
  logic                   start_ok;
  logic                   zero_len;
  logic                   out_of_range;
  logic                   pop;
  logic                   credit;
  logic                   issue;
  logic                   last_issue;
  logic                   capture;
  logic                   capture_last;

  assign start_ok     = start && gat_ready && (state == IDLE);
  assign end_word     = {2'b00, base_word} + {1'b0, num_words};
  assign zero_len     = (num_words == '0);
  assign out_of_range = (end_word > (AW + 2)'(NEW_FEATURE_DEPTH));

  assign m_tvalid     = !fifo_empty;
  assign pop          = m_tvalid && m_tready;

  // Words buffered or in flight, minus the one leaving this cycle, must stay
  // below the FIFO size for a new read to be safe.
  assign occupancy    = {1'b0, fifo_count} + {1'b0, inflight} - (CW + 1)'(pop);
  assign credit       = (occupancy < (CW + 1)'(FIFO_DEPTH));
  assign issue        = (state == ISSUE) && credit;
  assign last_issue   = issue && (remaining == (AW + 1)'(1));
  assign capture      = tag_v[RD_LATENCY-1];
  assign capture_last = tag_l[RD_LATENCY-1];

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = (zero_len || out_of_range) ? FIN : ISSUE;
      ISSUE:   if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (pop && m_tlast) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs decoded from state
  always_comb begin
    busy = (state == ISSUE) || (state == DRAIN);
    done = (state == FIN);
  end

  // Command latch, read address generation and range error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_idx        <= '0;
      remaining       <= '0;
      feat_bram_addrb <= '0;
      err_range       <= 1'b0;
    end else if (start_ok) begin
      word_idx  <= base_word;
      remaining <= num_words;
      err_range <= !zero_len && out_of_range;
    end else if (issue) begin
      feat_bram_addrb <= {word_idx, {BYTE_ADDR_SHIFT{1'b0}}};
      word_idx        <= word_idx + AW'(1);
      remaining       <= remaining - (AW + 1)'(1);
    end
  end

  // Read-latency tag pipeline and in-flight read counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v    <= '0;
      tag_l    <= '0;
      inflight <= '0;
    end else begin
      tag_v <= (tag_v << 1) | RD_LATENCY'(issue);
      tag_l <= (tag_l << 1) | RD_LATENCY'(last_issue);
      case ({issue, capture})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  gat_feat_rd_fifo #(
    .W     (NEW_FEATURE_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (capture),
    .push_data (feat_bram_dout),
    .push_last (capture_last),
    .pop       (pop),
    .head_data (m_tdata),
    .head_last (m_tlast),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef FEAT_RD_CHECKSUM_EN
  // Running sum of transferred words, restarted by each accepted command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        checksum <= '0;
    else if (start_ok) checksum <= '0;
    else if (pop)      checksum <= checksum + 32'(m_tdata);
  end
`endif

endmodule

// File: doc/gat_feat_bram_reader.md
Name: gat_feat_bram_reader

Overview:
Host-side reader for the new-feature BRAM read port exposed by the GAT top wrapper.
- After gat_ready asserts, a start command drains a contiguous word range of the feature BRAM.
- Drives the byte-addressed read port (feat_bram_addrb, word index in bits [ADDR_W+1:2]) and absorbs the fixed BRAM read latency.
- Emits words on a valid/ready stream with TLAST, so the DMA/AXI-Stream fabric in the block design can apply backpressure without losing in-flight reads.

Parameters:
NEW_FEATURE_WIDTH, 32, data width of feat_bram_dout and m_tdata
NUM_SUBGRAPHS, 2708, subgraph count (CORA)
NUM_FEATURE_OUT, 16, output features per subgraph
NEW_FEATURE_DEPTH, NUM_SUBGRAPHS*NUM_FEATURE_OUT, BRAM depth in words
NEW_FEATURE_ADDR_W, $clog2(NEW_FEATURE_DEPTH), word-address width
RD_LATENCY, 2, cycles from addrb change to valid dout (>=1)
FIFO_DEPTH, RD_LATENCY+2, prefetch buffer entries (power of 2 not required)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
gat_ready  in  1  accelerator finished; start is honoured only while high
start  in  1  single-cycle command strobe
base_word  in  NEW_FEATURE_ADDR_W  first word index to read
num_words  in  NEW_FEATURE_ADDR_W+1  words to read (0 allowed)
feat_bram_addrb  out  NEW_FEATURE_ADDR_W+2  byte address, bits [1:0] always 0
feat_bram_dout  in  NEW_FEATURE_WIDTH  BRAM read data
m_tdata  out  NEW_FEATURE_WIDTH  stream data
m_tvalid  out  1  stream valid
m_tready  in  1  stream ready
m_tlast  out  1  high with final word of command
busy  out  1  command in progress
done  out  1  one-cycle pulse when last word accepted (or at zero-length start)
err_range  out  1  sticky: command range exceeded NEW_FEATURE_DEPTH, cleared by next accepted start

Behaviour:
- Reset values: feat_bram_addrb=0, m_tdata=0, m_tvalid=0, m_tlast=0, busy=0, done=0, err_range=0. FSM goes to IDLE and the FIFO and in-flight counters clear. A reset mid-command discards all state.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
- IDLE: on start&&gat_ready, latch base/num and clear err_range.
  - If num_words==0: go to FIN (done next cycle, no stream beat).
  - If base_word+num_words>NEW_FEATURE_DEPTH: set err_range and go to FIN without reading.
  - Otherwise go to ISSUE with busy=1.
  - A start without gat_ready, or a start while busy, is ignored.
- ISSUE: issue one read per cycle when credit is available. Credit means fifo_count + inflight + (accepted this cycle ? -1 : 0) < FIFO_DEPTH. On issue, feat_bram_addrb={word_idx,2'b00}, then word_idx++ and remaining--. After the last issue, go to DRAIN.
- Read pipeline: a RD_LATENCY-deep valid shift register tags issued reads. When the tag exits, capture feat_bram_dout into the FIFO. A last flag travels with the tag for the final read.
- Stream: m_tvalid = FIFO not empty, and m_tdata/m_tlast come from the FIFO head (first-word-fall-through). A beat transfers on m_tvalid&&m_tready. m_tdata and m_tlast hold stable while valid is high and ready is low.
- DRAIN: wait for the transfer with m_tlast, then go to FIN.
- FIN: done=1 for one cycle, busy=0, return to IDLE. A start in FIN is ignored.
- Throughput: 1 word/cycle sustained with m_tready held high. First m_tvalid appears RD_LATENCY+1 cycles after the accepted start.
- The FIFO can never overflow, by credit. Simultaneous push and pop are allowed when full and when empty.
- feat_bram_addrb holds its last value when no read is issued.

Optional Feature:
FEAT_RD_CHECKSUM_EN
- Defined: adds output port checksum [31:0], the 32-bit wrap-around sum of all transferred m_tdata words in the current command. It is cleared on an accepted start and valid when done pulses.
- Undefined: the port and the adder are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package gat_feat_rd_pkg holds:
  - FSM state enum (IDLE/ISSUE/DRAIN/FIN)
  - NEW_FEATURE_DEPTH/ADDR_W derivation as localparams
  - BYTE_ADDR_SHIFT=2
- Sub-module gat_feat_rd_fifo: synchronous FWFT FIFO with data+last, parameterised depth, count output used for credit.

Test Plan:
- gat_ready=1, start, base=0, num=16, m_tready=1 -> 16 beats with words 0..15. Addrb sequence 0x0,0x4,...,0x3C. First valid 3 cycles after start. m_tlast on beat 16, done one cycle later.
- Same as above but m_tready toggles 1-of-3 -> no data loss or duplication, at most FIFO_DEPTH outstanding, tdata held stable while stalled.
- num_words=0 -> no m_tvalid, done pulses exactly once, busy stays 0 after FIN.
- base=43320, num=16 -> err_range=1, no reads issued, done pulses. The next valid start clears err_range.
- start with gat_ready=0, and a second start mid-command -> both ignored, and the original command completes unchanged.
- rst_n asserted after 5 of 32 beats -> all outputs 0 immediately. A fresh start then streams from its new base correctly.
